// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared types and constants for the truth-table sweeper
//
// Purpose: the FSM state type, the largest supported input count, and the
// helper that turns an input count into a mask width.
package truth_table_pkg;

    localparam int N_IN_MAX = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int mask_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - input-vector index counter for the truth-table sweeper
//
// Purpose: holds the current input-vector index. It is cleared by load_zero_i
// and advances on each accepted beat. It saturates at the last index, so it
// never wraps back to 0.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   load_zero_i  clear the index to 0 (has priority over advance_i)
//   advance_i    step to the next index
//   idx_o        current index
//   last_o       high when idx_o is the final index (all ones)
module sweep_counter #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_zero_i,
    input  logic            advance_i,
    output logic [N_IN-1:0] idx_o,
    output logic            last_o
);

    logic [N_IN-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load_zero_i) begin
            idx_d = '0;
        end else if (advance_i && !last_o) begin
            idx_d = idx_q + N_IN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == {N_IN{1'b1}});

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sequential evaluator of an N-input minterm-mask function
//
// Purpose: on start, walks every input combination in ascending order. Each
// vector and its function value are streamed over a valid/ready handshake.
// The block accumulates a ones count and the index of the first true beat.
// Optional feature macro: TT_CROSSCHECK_EN. When it is defined, a latched
// maxterm mask is checked against the minterm mask on every accepted beat.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a sweep (only honoured in IDLE)
//   minterm_mask    f(i)=1 where bit i set; latched on accepted start
//   maxterm_mask    f(i)=0 where bit i set; latched only with cross-check
//   busy            high in SWEEP and DONE
//   vec_valid       beat valid
//   vec_ready       consumer accepts beat
//   vec_idx         input vector, MSB = first input
//   vec_val         f(vec_idx)
//   done            one-cycle pulse after the last beat is accepted
//   ones_count      accepted beats whose value was 1
//   has_one         at least one true beat seen
//   first_one_idx   index of the first true beat (0 if none)
//   mismatch        sticky cross-check failure
//   mismatch_idx    index of the first cross-check failure
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int MASK_W = mask_width(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MASK_W-1:0] minterm_mask,
    input  logic [MASK_W-1:0] maxterm_mask,
    output logic              busy,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [N_IN-1:0]   vec_idx,
    output logic              vec_val,
    output logic              done,
    output logic [N_IN:0]     ones_count,
    output logic              has_one,
    output logic [N_IN-1:0]   first_one_idx,
    output logic              mismatch,
    output logic [N_IN-1:0]   mismatch_idx
);

    state_e            state_q, state_d;
    logic [MASK_W-1:0] minterm_q, minterm_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic              has_one_q, has_one_d;
    logic [N_IN-1:0]   first_q, first_d;

    logic [N_IN-1:0]   idx;
    logic              last_idx;
    logic              accept_start;
    logic              beat_accept;
    logic              cur_val;

    assign accept_start = (state_q == IDLE) && start;
    assign beat_accept  = (state_q == SWEEP) && vec_ready;

    sweep_counter #(.N_IN(N_IN)) u_counter (
        .clk         (clk),
        .rst         (rst),
        .load_zero_i (accept_start),
        .advance_i   (beat_accept),
        .idx_o       (idx),
        .last_o      (last_idx)
    );

    // The value is looked up from registered state only, so vec_val
    // has no combinational path from vec_ready or start.
    assign cur_val = minterm_q[idx];

    always_comb begin
        state_d   = state_q;
        minterm_d = minterm_q;
        ones_d    = ones_q;
        has_one_d = has_one_q;
        first_d   = first_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SWEEP;
                    minterm_d = minterm_mask;
                    ones_d    = '0;
                    has_one_d = 1'b0;
                    first_d   = '0;
                end
            end
            SWEEP: begin
                if (vec_ready) begin
                    if (cur_val) begin
                        // Never wraps: at most MASK_W ones fit in N_IN+1 bits.
                        ones_d = ones_q + (N_IN+1)'(1);
                        if (!has_one_q) begin
                            has_one_d = 1'b1;
                            first_d   = idx;
                        end
                    end
                    if (last_idx) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            minterm_q <= '0;
            ones_q    <= '0;
            has_one_q <= 1'b0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            minterm_q <= minterm_d;
            ones_q    <= ones_d;
            has_one_q <= has_one_d;
            first_q   <= first_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign vec_valid     = (state_q == SWEEP);
    assign done          = (state_q == DONE);
    assign vec_idx       = idx;
    assign vec_val       = cur_val;
    assign ones_count    = ones_q;
    assign has_one       = has_one_q;
    assign first_one_idx = first_q;

`ifdef TT_CROSSCHECK_EN
    logic [MASK_W-1:0] maxterm_q, maxterm_d;
    logic              mm_q, mm_d;
    logic [N_IN-1:0]   mm_idx_q, mm_idx_d;

    // An index is consistent only when exactly one form covers it. Equal
    // bits mean both claim it, or neither does.
    always_comb begin
        maxterm_d = maxterm_q;
        mm_d      = mm_q;
        mm_idx_d  = mm_idx_q;
        if (accept_start) begin
            maxterm_d = maxterm_mask;
            mm_d      = 1'b0;
            mm_idx_d  = '0;
        end else if (beat_accept && !mm_q && (minterm_q[idx] == maxterm_q[idx])) begin
            mm_d     = 1'b1;
            mm_idx_d = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            maxterm_q <= '0;
            mm_q      <= 1'b0;
            mm_idx_q  <= '0;
        end else begin
            maxterm_q <= maxterm_d;
            mm_q      <= mm_d;
            mm_idx_q  <= mm_idx_d;
        end
    end

    assign mismatch     = mm_q;
    assign mismatch_idx = mm_idx_q;
`else
    logic unused_maxterm;
    assign unused_maxterm = ^maxterm_mask;
    assign mismatch       = 1'b0;
    assign mismatch_idx   = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // N_IN = 4 instance
    logic        s4_start, s4_ready;
    logic [15:0] s4_min, s4_max;
    logic        s4_busy, s4_valid, s4_val, s4_done, s4_has_one, s4_mm;
    logic [3:0]  s4_idx, s4_first, s4_mm_idx;
    logic [4:0]  s4_ones;

    // N_IN = 1 instance
    logic        s1_start, s1_ready;
    logic [1:0]  s1_min, s1_max;
    logic        s1_busy, s1_valid, s1_val, s1_done, s1_has_one, s1_mm;
    logic [0:0]  s1_idx, s1_first, s1_mm_idx;
    logic [1:0]  s1_ones;

    int n_vec = 0;
    int n_err = 0;

    truth_table_sweeper #(.N_IN(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start),
        .minterm_mask(s4_min), .maxterm_mask(s4_max),
        .busy(s4_busy), .vec_valid(s4_valid), .vec_ready(s4_ready),
        .vec_idx(s4_idx), .vec_val(s4_val), .done(s4_done),
        .ones_count(s4_ones), .has_one(s4_has_one), .first_one_idx(s4_first),
        .mismatch(s4_mm), .mismatch_idx(s4_mm_idx)
    );

    truth_table_sweeper #(.N_IN(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start),
        .minterm_mask(s1_min), .maxterm_mask(s1_max),
        .busy(s1_busy), .vec_valid(s1_valid), .vec_ready(s1_ready),
        .vec_idx(s1_idx), .vec_val(s1_val), .done(s1_done),
        .ones_count(s1_ones), .has_one(s1_has_one), .first_one_idx(s1_first),
        .mismatch(s1_mm), .mismatch_idx(s1_mm_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic over the mask bits.
    function automatic int ref_ones(input logic [15:0] m);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic int ref_first(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Returns -1 when every index is covered by exactly one form.
    function automatic int ref_mm(input logic [15:0] mi, input logic [15:0] ma);
        for (int i = 0; i < 16; i++) if (mi[i] == ma[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ready always 1, 1 ready toggles 1,0,1..., 2 random ready.
    // poke: pulse start randomly during SWEEP and assert it in the DONE cycle.
    // k returns the done cycle relative to the start edge.
    task automatic sweep4(input logic [15:0] mint, input logic [15:0] maxt,
                          input int mode, input bit poke, output int k);
        int  e;
        int  lows;
        int  run_ones;
        int  mmi;
        bit  r;
        bit  tog;
        s4_min   = mint;
        s4_max   = maxt;
        s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        s4_min   = 16'($urandom);
        s4_max   = 16'($urandom);
        k = 1; e = 0; lows = 0; run_ones = 0; tog = 1'b1;
        while (e < 16 && k < 120) begin
            check("beat_valid", s4_valid, 1);
            check("beat_busy", s4_busy, 1);
            check("beat_idx", s4_idx, e);
            check("beat_val", s4_val, mint[e]);
            check("run_ones", s4_ones, run_ones);
            case (mode)
                0:       r = 1'b1;
                1:       begin r = tog; tog = ~tog; end
                default: r = ($urandom % 4) != 0;
            endcase
            s4_ready = r;
            s4_start = poke ? 1'($urandom % 2) : 1'b0;
            if (r) begin
                run_ones += int'(mint[e]);
                e++;
            end else begin
                lows++;
            end
            tick();
            k++;
        end
        check("sweep_complete", e, 16);
        check("done_pulse", s4_done, 1);
        check("done_valid_low", s4_valid, 0);
        check("done_busy", s4_busy, 1);
        check("done_cycle", k, 16 + lows + 1);
        s4_ready = 1'($urandom);
        s4_start = poke;
        tick();
        s4_start = 1'b0;
        check("post_done_low", s4_done, 0);
        check("post_idle", s4_busy, 0);
        check("res_ones", s4_ones, ref_ones(mint));
        check("res_has_one", s4_has_one, mint != 0);
        check("res_first", s4_first, ref_first(mint));
        mmi = ref_mm(mint, maxt);
`ifdef TT_CROSSCHECK_EN
        check("res_mismatch", s4_mm, mmi >= 0);
        check("res_mm_idx", s4_mm_idx, (mmi >= 0) ? mmi : 0);
`else
        check("res_mismatch", s4_mm, 0);
        check("res_mm_idx", s4_mm_idx, 0);
`endif
    endtask

    initial begin
        int  k;
        bit  seen_done;
        logic [15:0] m, x;

        rst = 1'b1;
        s4_start = 0; s4_ready = 0; s4_min = 0; s4_max = 0;
        s1_start = 0; s1_ready = 0; s1_min = 0; s1_max = 0;
        repeat (3) tick();
        check("rst_busy", s4_busy, 0);
        check("rst_valid", s4_valid, 0);
        check("rst_done", s4_done, 0);
        check("rst_idx", s4_idx, 0);
        check("rst_val", s4_val, 0);
        check("rst_ones", s4_ones, 0);
        check("rst_has_one", s4_has_one, 0);
        check("rst_first", s4_first, 0);
        check("rst_mm", s4_mm, 0);
        check("rst_mm_idx", s4_mm_idx, 0);
        check("rst1_busy", s1_busy, 0);
        rst = 1'b0;
        tick();

        // Reference function 0xACBA, complementary maxterm mask.
        sweep4(16'hACBA, 16'h5345, 0, 1'b0, k);
        check("acba_done_cycle", k, 17);
        check("acba_ones", s4_ones, 9);
        check("acba_first", s4_first, 1);
        // Back-to-back start in the first IDLE cycle, maxterm with index 1 doubled.
        sweep4(16'hACBA, 16'h5347, 0, 1'b0, k);

        // Alternating ready, all-ones function.
        sweep4(16'hFFFF, 16'h0000, 1, 1'b0, k);
        check("toggle_done_cycle", k, 32);
        check("toggle_ones_nowrap", s4_ones, 16);

        // Start pulses during SWEEP and DONE must be ignored.
        sweep4(16'h1234, 16'hEDCB, 0, 1'b1, k);
        check("poke_done_cycle", k, 17);

        // Reset at beat 5 aborts the sweep without a done pulse.
        s4_min = 16'hFFFF; s4_ready = 1'b1; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        for (int i = 0; i < 20 && s4_idx != 4'd5; i++) tick();
        check("abort_reached_beat5", s4_idx, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", s4_busy, 0);
        check("abort_valid", s4_valid, 0);
        check("abort_ones", s4_ones, 0);
        check("abort_has_one", s4_has_one, 0);
        check("abort_idx", s4_idx, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen_done |= s4_done;
            tick();
        end
        check("abort_no_done", seen_done, 0);
        sweep4(16'h0000, 16'hFFFF, 0, 1'b0, k);
        check("zero_ones", s4_ones, 0);
        check("zero_has_one", s4_has_one, 0);
        check("zero_first", s4_first, 0);

        // Randomized sweeps.
        for (int n = 0; n < 10; n++) begin
            m = 16'($urandom);
            x = ($urandom % 2) ? ~m : (~m ^ (16'h1 << ($urandom % 16)));
            if (n == 0) m = 16'h8000;
            sweep4(m, x, 2, 1'b1, k);
        end

        // N_IN = 1 instance, minterm 2'b10.
        s1_min = 2'b10; s1_ready = 1'b1; s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        s1_min = 2'b01;
        check("n1_b0_valid", s1_valid, 1);
        check("n1_b0_idx", s1_idx, 0);
        check("n1_b0_val", s1_val, 0);
        tick();
        check("n1_b1_idx", s1_idx, 1);
        check("n1_b1_val", s1_val, 1);
        tick();
        check("n1_done_t3", s1_done, 1);
        check("n1_done_valid", s1_valid, 0);
        tick();
        check("n1_idle", s1_busy, 0);
        check("n1_ones", s1_ones, 1);
        check("n1_has_one", s1_has_one, 1);
        check("n1_first", s1_first, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential, parametrised evaluator for an N-input Boolean function given as a minterm mask. On `start` it walks all 2^N_IN input combinations in ascending order, streams each input vector and function value through a valid/ready handshake, and accumulates a ones count and the first true index. With the cross-check build option, it also checks a maxterm (PoS) mask against the minterm (SoP) mask and flags disagreement. It serves as the hardware successor to the fixed 4-input SoP/PoS truth-table exercises, usable as a self-checking pattern source.

## Interface
- `N_IN`, default 4: number of function inputs; legal range 1..6.
- `MASK_W`, default 2**N_IN: mask width; derived, not overridden.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a sweep; honoured only in IDLE
- `minterm_mask`  in  MASK_W  bit i = 1 means f(i) = 1; sampled on accepted `start`
- `maxterm_mask`  in  MASK_W  bit i = 1 means f(i) = 0; sampled on accepted `start`; ignored without `TT_CROSSCHECK_EN`
- `busy`  out  1  high in SWEEP and DONE
- `vec_valid`  out  1  current beat valid
- `vec_ready`  in  1  consumer accepts beat
- `vec_idx`  out  N_IN  input vector {a,b,c,...}, MSB = first input
- `vec_val`  out  1  f(vec_idx)
- `done`  out  1  one-cycle pulse after last beat accepted
- `ones_count`  out  N_IN+1  number of accepted beats with `vec_val` = 1
- `has_one`  out  1  at least one true beat seen
- `first_one_idx`  out  N_IN  index of first true beat; 0 if none
- `mismatch`  out  1  sticky cross-check failure (0 without macro)
- `mismatch_idx`  out  N_IN  first failing index (0 without macro)

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE: `start` = 1 latches both masks, clears ones_count, has_one, first_one_idx, mismatch, and mismatch_idx, sets idx to 0, and moves to SWEEP.
- SWEEP: `vec_valid` = 1, `vec_val` = latched_minterm[vec_idx]. A beat is accepted when valid and ready. On acceptance:
  - If `vec_val`, increment `ones_count`.
  - If `vec_val` and `!has_one`, capture `first_one_idx` and set `has_one`.
  - If idx = MASK_W−1, go to DONE; otherwise increment idx.
- `vec_ready` = 0 holds idx, `vec_val`, and all accumulators.
- DONE: one cycle with `done` = 1 and `vec_valid` = 0, then IDLE.
- `start` in SWEEP or DONE is ignored; it is not queued.
- Results (`ones_count`, `has_one`, `first_one_idx`, `mismatch`, `mismatch_idx`) hold their values until the next accepted `start`.
- Mask inputs may change during a sweep with no effect.
- `ones_count` covers the range 0..MASK_W; it never wraps.
- idx does not wrap past MASK_W−1.

## Timing
- Reset values: state IDLE; `busy`, `vec_valid`, `done`, `has_one`, `mismatch` = 0; `vec_idx`, `vec_val`, `ones_count`, `first_one_idx`, `mismatch_idx` = 0.
- Reset mid-sweep aborts immediately. No `done` pulse is produced.
- Start at cycle t puts the first beat (idx 0) valid at t+1.
- With `vec_ready` held at 1, beats occupy t+1..t+MASK_W, `done` fires at t+MASK_W+1, and IDLE is entered at t+MASK_W+2. A `start` at t+MASK_W+2 is accepted.
- Each low cycle of `vec_ready` during SWEEP delays `done` by one cycle.
- All outputs are registered; there is no combinational path from `vec_ready` or `start` to any output.

## Configuration
- `TT_CROSSCHECK_EN` defined:
  - On every accepted beat, flag a failure if latched_minterm[i] == latched_maxterm[i], i.e. both forms claim 1/0 or neither covers i.
  - The first failure sets `mismatch` and captures `mismatch_idx`. Later failures do not overwrite it.
  - The check is updated in the same cycle as the accumulators.
- `TT_CROSSCHECK_EN` undefined:
  - `maxterm_mask` is unused.
  - `mismatch` and `mismatch_idx` are tied to 0.
  - No maxterm register is built.

## Structure
- Package `truth_table_pkg`:
  - state enum {IDLE, SWEEP, DONE}
  - `N_IN_MAX` = 6 constant
  - mask-width function 2**n
- Sub-module `sweep_counter` is the natural split. It contains the idx counter with load-zero, advance-on-accept, and a last-index flag.
- The top level holds the FSM, mask registers, accumulators, and cross-check logic.

## Test plan
- N_IN=4, minterm 0xACBA (minterms 1,3,4,5,7,A,B,D,F), `vec_ready`=1, start → 16 beats, `vec_val` sequence 0,1,0,1,1,1,0,1,0,0,1,1,0,1,0,1, `ones_count`=9, `first_one_idx`=1, `done` at t+17.
- Same run with macro on, maxterm 0x5345 (0,2,6,8,9,C,E) → `mismatch`=0. With maxterm 0x5347 → `mismatch`=1, `mismatch_idx`=1.
- `vec_ready` toggling 1,0,1,0… with minterm 0xFFFF → idx held while ready is 0, `ones_count`=16 with no wrap, `done` at t+32.
- Reset asserted at beat 5, then start with 0x0000 → no `done` from the aborted run, `ones_count`=0, `has_one`=0, `first_one_idx`=0.
- `start` pulsed during SWEEP and during the DONE cycle → ignored. Back-to-back start in the first IDLE cycle → accepted, first beat one cycle later.
- N_IN=1, minterm 2'b10 → beats idx 0 (val 0) and idx 1 (val 1), `ones_count`=1, `first_one_idx`=1, `done` at t+3.
